// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor ramp controller.
package motor_pkg;

  typedef enum logic [1:0] {StBrake, StRun, StDead} ch_state_e;

  // Magnitude of a w-bit signed value; the most negative code saturates to 2^(w-1)-1.
  function automatic int sat_mag(input int v, input int unsigned w);
    int lim;
    lim = (1 << (w - 1)) - 1;
    if (v < -lim) return lim;
    else if (v < 0) return -v;
    else return v;
  endfunction

endpackage

// File: rtl/motor_ramp_ch.sv
// One motor channel: speed ramp FSM, reversal coast timer and registered PWM drive pair.
module motor_ramp_ch
  import motor_pkg::*;
#(
  parameter int unsigned SPD_W = 11,
  parameter int unsigned STEP  = 8,
  parameter int unsigned DEAD  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               strb_i,
  input  logic [SPD_W-2:0]   cnt_i,
  input  logic [SPD_W-1:0]   spd_i,
  output logic               fwd_o,
  output logic               rev_o,
  output logic               settled_o
);

  localparam int unsigned MAG_W = SPD_W - 1;
  localparam int unsigned DW    = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
  localparam logic signed [SPD_W:0] StepW  = (SPD_W + 1)'(STEP);
  localparam logic        [DW-1:0]  DeadLd = DW'(DEAD);

  ch_state_e               state_q, state_d;
  logic signed [SPD_W-1:0] cur_q, cur_d;
  logic        [DW-1:0]    dcnt_q, dcnt_d;
  logic                    fwd_q, fwd_d, rev_q, rev_d;

  logic        [MAG_W-1:0] tgt_mag, cur_mag;
  logic signed [SPD_W:0]   tgt_w, cur_w, diff, stepped, toward0;
  logic                    opposite;

  // One extra bit of headroom so +/-STEP never wraps near full scale.
  assign tgt_mag = MAG_W'(sat_mag(int'($signed(spd_i)), SPD_W));
  assign tgt_w   = spd_i[SPD_W-1] ? -$signed({2'b00, tgt_mag}) : $signed({2'b00, tgt_mag});
  assign cur_w   = $signed({cur_q[SPD_W-1], cur_q});
  assign cur_mag = MAG_W'(cur_q[SPD_W-1] ? -cur_w : cur_w);
  assign diff    = tgt_w - cur_w;

  assign opposite = (cur_q[SPD_W-1] && !tgt_w[SPD_W] && (tgt_w != '0)) ||
                    (!cur_q[SPD_W-1] && (cur_q != '0) && tgt_w[SPD_W]);

  always_comb begin
    stepped = tgt_w;
    if (diff > StepW)       stepped = cur_w + StepW;
    else if (diff < -StepW) stepped = cur_w - StepW;
    toward0 = '0;
    if (cur_w > StepW)       toward0 = cur_w - StepW;
    else if (cur_w < -StepW) toward0 = cur_w + StepW;
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dcnt_d  = dcnt_q;
    fwd_d   = 1'b0;
    rev_d   = 1'b0;
    if (!en_i) begin
      state_d = StBrake;
      cur_d   = '0;
      dcnt_d  = '0;
    end else begin
      unique case (state_q)
        StDead: begin
          if (dcnt_q <= DW'(1)) begin
            state_d = StBrake;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q - DW'(1);
          end
        end
        default: begin
          if (strb_i) begin
            if (opposite) begin
              cur_d = SPD_W'(toward0);
              if (toward0 == '0) begin
                state_d = StDead;
                dcnt_d  = DeadLd;
              end
            end else begin
              cur_d   = SPD_W'(stepped);
              state_d = (stepped == '0) ? StBrake : StRun;
            end
          end
        end
      endcase

      unique case (state_q)
        StBrake: begin
          fwd_d = 1'b1;
          rev_d = 1'b1;
        end
        StDead: ;
        default: begin
          if (cur_q[SPD_W-1]) rev_d = (cnt_i < cur_mag);
          else                fwd_d = (cnt_i < cur_mag);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBrake;
      cur_q   <= '0;
      dcnt_q  <= '0;
      fwd_q   <= 1'b0;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dcnt_q  <= dcnt_d;
      fwd_q   <= fwd_d;
      rev_q   <= rev_d;
    end
  end

  assign fwd_o     = fwd_q;
  assign rev_o     = rev_q;
  assign settled_o = (cur_w == tgt_w) && (state_q != StDead);

endmodule

// File: rtl/motor_ramp_cntrl.sv
// Multi-channel motor ramp controller: shared PWM period counter feeding NCH ramp channels.
module motor_ramp_cntrl
  import motor_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned SPD_W = 11,
  parameter int unsigned STEP  = 8,
  parameter int unsigned DEAD  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NCH*SPD_W-1:0] spd,
  output logic [NCH-1:0]       fwd,
  output logic [NCH-1:0]       rev,
  output logic                 period_strb,
  output logic [NCH-1:0]       settled
);

  localparam int unsigned MAG_W = SPD_W - 1;

  logic [MAG_W-1:0] cnt_q, cnt_d;

  assign cnt_d       = cnt_q + MAG_W'(1);
  assign period_strb = &cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    motor_ramp_ch #(
      .SPD_W (SPD_W),
      .STEP  (STEP),
      .DEAD  (DEAD)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en),
      .strb_i    (period_strb),
      .cnt_i     (cnt_q),
      .spd_i     (spd[i*SPD_W +: SPD_W]),
      .fwd_o     (fwd[i]),
      .rev_o     (rev[i]),
      .settled_o (settled[i])
    );
  end

endmodule
